// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with registered detect pulse,
// overlap/non-overlap matching and a saturating match counter.
module seq_detector_param #(
    parameter int unsigned     LEN         = 4,
    parameter logic [LEN-1:0]  DEF_PATTERN = LEN'(4'b1001),
    parameter logic            DEF_OVERLAP = 1'b1,
    parameter int unsigned     CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [LEN-1:0]   cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             detect,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned FW = $clog2(LEN + 1);

    logic [LEN-1:0]   pattern;
    logic             overlap;
    logic [LEN-1:0]   hist;
    logic [FW-1:0]    fill;

    logic [LEN-1:0]   hist_next;
    logic [FW-1:0]    fill_inc;
    logic             match;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        hist_next = {hist[LEN-2:0], in_bit};
        fill_inc  = (fill == FW'(LEN)) ? fill : fill + 1'b1;
        // fill+1 >= LEN keeps reset zeros from completing a pattern
        match     = in_valid && !cfg_load && (hist_next == pattern)
                    && (fill >= FW'(LEN - 1));

        cnt_next = match_cnt;
        if (cnt_clr) begin
            cnt_next = match ? CNT_W'(1) : '0;
        end else if (match && (match_cnt != '1)) begin
            cnt_next = match_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern   <= DEF_PATTERN;
            overlap   <= DEF_OVERLAP;
            hist      <= '0;
            fill      <= '0;
            detect    <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            detect    <= match;
            match_cnt <= cnt_next;
            cnt_sat   <= &cnt_next;
            if (cfg_load) begin
                pattern <= cfg_pattern;
                overlap <= cfg_overlap;
                hist    <= '0;
                fill    <= '0;
            end else if (in_valid) begin
                hist <= hist_next;
                fill <= (match && !overlap) ? '0 : fill_inc;
            end
        end
    end

endmodule
